score_display_ctrl: RTL and testbench

Sequential controller for the score readout on the three right-hand seven-segment displays. It accepts an 8-bit binary score with a valid strobe and converts it to three BCD digits using an iterative shift-add-3 (double-dabble) engine, one bit per cycle. It then latches the digits and drives HEX2..HEX0 with leading-zero blanking and a game-over blink mode. It sits between the game-state logic, which produces the score, and the board HEX pins.

---
 rtl/score_display_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_score_display_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/score_display_ctrl.sv
// score_display_ctrl
//   Converts an 8-bit binary score to three BCD digits (iterative
//   shift-add-3, one bit per cycle) and drives three active-low
//   seven-segment displays with leading-zero blanking and a game-over
//   blink mode.
// Ports:
//   clk          rising-edge system clock
//   reset        asynchronous, active-high reset
//   score        binary score 0..255, sampled when score_valid=1
//   score_valid  one-cycle request to display score
//   game_over    level; while high the display blinks
//   busy         conversion in progress (SHIFT or LATCH)
//   done         one-cycle pulse, coincident with the HEX update
//   HEX0/1/2     ones/tens/hundreds, active-low, bit0=a .. bit6=g
module score_display_ctrl #(
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] score,
  input  logic       score_valid,
  input  logic       game_over,
  output logic       busy,
  output logic       done,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;

  localparam int unsigned CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] BLINK_MAX = CW'(BLINK_DIV - 1);
  localparam logic [6:0] BLANK = 7'h7F;

  logic [1:0]    state_q, state_d;
  logic [19:0]   sr_q, sr_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [7:0]    pval_q, pval_d;
  logic [3:0]    d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
  logic          done_q, done_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic [6:0]    hex0_q, hex0_d, hex1_q, hex1_d, hex2_q, hex2_d;
  logic [19:0]   adj;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = BLANK;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    pval_d  = pval_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    done_d  = 1'b0;
    adj     = sr_q;

    case (state_q)
      IDLE: begin
        if (pend_q || score_valid) begin
          sr_d    = {12'b0, (pend_q ? pval_q : score)};
          cnt_d   = '0;
          state_d = SHIFT;
          pend_d  = 1'b0;
          // A new request arriving while a pending one is being launched
          // becomes the next pending value rather than being dropped.
          if (pend_q && score_valid) begin
            pend_d = 1'b1;
            pval_d = score;
          end
        end
      end
      SHIFT: begin
        if (adj[19:16] >= 4'd5) adj[19:16] = adj[19:16] + 4'd3;
        if (adj[15:12] >= 4'd5) adj[15:12] = adj[15:12] + 4'd3;
        if (adj[11:8]  >= 4'd5) adj[11:8]  = adj[11:8]  + 4'd3;
        sr_d  = {adj[18:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = LATCH;
      end
      LATCH: begin
        d2_d    = sr_q[19:16];
        d1_d    = sr_q[15:12];
        d0_d    = sr_q[11:8];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Requests during a conversion overwrite any earlier pending value.
    if (state_q != IDLE && score_valid) begin
      pend_d = 1'b1;
      pval_d = score;
    end
  end

  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (!game_over) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (bcnt_q == BLINK_MAX) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end else begin
      bcnt_d = bcnt_q + CW'(1);
    end
  end

  // HEX registers are computed from next-state digits and phase so the
  // displayed value changes on the same edge that raises done.
  always_comb begin
    hex2_d = (d2_d == 4'd0) ? BLANK : seg7(d2_d);
    hex1_d = (d2_d == 4'd0 && d1_d == 4'd0) ? BLANK : seg7(d1_d);
    hex0_d = seg7(d0_d);
    if (phase_d) begin
      hex2_d = BLANK;
      hex1_d = BLANK;
      hex0_d = BLANK;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      pval_q  <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      done_q  <= 1'b0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      hex0_q  <= 7'h40;
      hex1_q  <= BLANK;
      hex2_q  <= BLANK;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pval_q  <= pval_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      done_q  <= done_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      hex0_q  <= hex0_d;
      hex1_q  <= hex1_d;
      hex2_q  <= hex2_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign HEX0 = hex0_q;
  assign HEX1 = hex1_q;
  assign HEX2 = hex2_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
module tb_score_display_ctrl;

  localparam int unsigned BD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] score;
  logic       score_valid;
  logic       game_over;
  logic       busy;
  logic       done;
  logic [6:0] HEX0, HEX1, HEX2;

  int tests = 0;
  int fails = 0;

  logic [6:0] SEG [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  score_display_ctrl #(.BLINK_DIV(BD)) dut (
    .clk(clk), .reset(reset), .score(score), .score_valid(score_valid),
    .game_over(game_over), .busy(busy), .done(done),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2)
  );

  always #5 clk = ~clk;

  // Expected {HEX2,HEX1,HEX0} for a visible score, from decimal arithmetic.
  function automatic logic [20:0] model(input int s);
    int h, t, o;
    logic [6:0] e2, e1, e0;
    h  = s / 100;
    t  = (s / 10) % 10;
    o  = s % 10;
    e2 = (h == 0) ? 7'h7F : SEG[h];
    e1 = (h == 0 && t == 0) ? 7'h7F : SEG[t];
    e0 = SEG[o];
    return {e2, e1, e0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Request v; done and new digits must appear exactly 9 edges later.
  task automatic convert(input int v);
    score = 8'(v);
    score_valid = 1'b1;
    tick();                                  // edge E
    score_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check("busy_during", 32'(busy), 32'd1);
      check("done_early", 32'(done), 32'd0);
      tick();
    end
    tick();                                  // edge E+9
    check("done_pulse", 32'(done), 32'd1);
    check("busy_fall", 32'(busy), 32'd0);
    check($sformatf("hex_%0d", v), 32'({HEX2, HEX1, HEX0}), 32'(model(v)));
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int ndone;
    int r;
    reset = 1'b1;
    score = '0;
    score_valid = 1'b0;
    game_over = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hex", 32'({HEX2, HEX1, HEX0}), 32'({7'h7F, 7'h7F, 7'h40}));
    reset = 1'b0;
    tick();
    check("idle_hex", 32'({HEX2, HEX1, HEX0}), 32'({7'h7F, 7'h7F, 7'h40}));

    convert(0);
    convert(255);
    check("255_lit", 32'({HEX2, HEX1, HEX0}), 32'({7'h24, 7'h12, 7'h12}));
    convert(107);
    check("107_lit", 32'({HEX2, HEX1, HEX0}), 32'({7'h79, 7'h40, 7'h78}));
    convert(9);
    convert(60);
    convert(100);
    convert(10);

    for (int i = 0; i < 20; i++) begin
      r = int'($urandom_range(0, 255));
      convert(r);
    end

    // Pending requests: 17 is superseded by 42; second done 10 edges after first.
    score = 8'd199;
    score_valid = 1'b1;
    tick();                                  // edge E
    score_valid = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 2) begin score = 8'd17; score_valid = 1'b1; end
      else if (k == 4) begin score = 8'd42; score_valid = 1'b1; end
      else score_valid = 1'b0;
      tick();                                // edge E+k
      if (done) ndone++;
      if (k == 9) begin
        check("pend_first_done", 32'(done), 32'd1);
        check("pend_first_hex", 32'({HEX2, HEX1, HEX0}), 32'(model(199)));
      end
      if (k == 10) check("pend_restart_busy", 32'(busy), 32'd1);
      if (k == 19) begin
        check("pend_second_done", 32'(done), 32'd1);
        check("pend_second_hex", 32'({HEX2, HEX1, HEX0}), 32'({7'h7F, 7'h19, 7'h24}));
      end
    end
    check("pend_done_count", 32'(ndone), 32'd2);

    // Blink: phase after k edges of game_over is (k / BD) % 2.
    game_over = 1'b1;
    for (int k = 1; k <= 4 * BD + 3; k++) begin
      tick();
      if (((k / BD) % 2) == 1)
        check($sformatf("blink_blank_%0d", k), 32'({HEX2, HEX1, HEX0}), 32'h1FFFFF);
      else
        check($sformatf("blink_vis_%0d", k), 32'({HEX2, HEX1, HEX0}), 32'(model(42)));
    end
    game_over = 1'b0;
    tick();
    check("blink_off_vis", 32'({HEX2, HEX1, HEX0}), 32'(model(42)));

    // Conversion completes normally while blanked; digits still update.
    game_over = 1'b1;
    score = 8'd123;
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (done) ndone++;
    end
    check("blanked_done", 32'(ndone), 32'd1);
    game_over = 1'b0;
    tick();
    check("blanked_digits", 32'({HEX2, HEX1, HEX0}), 32'(model(123)));

    // Reset mid-conversion at E+4.
    score = 8'd200;
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hex", 32'({HEX2, HEX1, HEX0}), 32'({7'h7F, 7'h7F, 7'h40}));
    tick();
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done || busy) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    check("midrst_hex_after", 32'({HEX2, HEX1, HEX0}), 32'({7'h7F, 7'h7F, 7'h40}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
